// File: rtl/exec_core_if.sv
// exec_core_if: instruction/observe bundle between the ROM side and exec_core.
//   INSTR     ROM word: opcode nibble on top, immediate in the low DATA_WIDTH bits
//   RST_CODE  combinational restart request to the program counter
//   ACC_OUT   accumulator register
//   R0_OUT    general register R0
//   ALU_OUT   combinational ALU result (observe only)
// master = ROM/sequencer side, slave = exec_core.
interface exec_core_if #(
  parameter int unsigned DATA_WIDTH = 4
);
  logic [DATA_WIDTH+3:0] INSTR;
  logic                  RST_CODE;
  logic [DATA_WIDTH-1:0] ACC_OUT;
  logic [DATA_WIDTH-1:0] R0_OUT;
  logic [DATA_WIDTH-1:0] ALU_OUT;

  modport master (
    output INSTR,
    input  RST_CODE,
    input  ACC_OUT,
    input  R0_OUT,
    input  ALU_OUT
  );

  modport slave (
    input  INSTR,
    output RST_CODE,
    output ACC_OUT,
    output R0_OUT,
    output ALU_OUT
  );
endinterface

// File: rtl/exec_core.sv
// exec_core: decode/execute slice of the 4-bit accumulator microprocessor.
// Decodes the opcode nibble of INSTR, selects ACC or the immediate as ALU
// operand 0 (operand 1 is always R0), and updates ACC / R0 once per cycle.
// Ports:
//   CLK  rising-edge clock
//   RST  synchronous active-high reset; clears ACC and R0, overrides enables
//   bus  exec_core_if.slave: INSTR in; RST_CODE, ACC_OUT, R0_OUT, ALU_OUT out
module exec_core #(
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned OP_WIDTH   = 2
) (
  input  logic         CLK,
  input  logic         RST,
  exec_core_if.slave   bus
);

  typedef enum logic [3:0] {
    OPC_NOP  = 4'h0,
    OPC_LDI  = 4'h1,
    OPC_MOV  = 4'h2,
    OPC_ADD  = 4'h3,
    OPC_SUB  = 4'h4,
    OPC_AND  = 4'h5,
    OPC_ADDI = 4'h6,
    OPC_SUBI = 4'h7,
    OPC_ANDI = 4'h8,
    OPC_RST  = 4'hF
  } opcode_e;

  typedef enum logic [OP_WIDTH-1:0] {
    ALU_PASS = 2'b00,
    ALU_ADD  = 2'b01,
    ALU_SUB  = 2'b10,
    ALU_AND  = 2'b11
  } alu_op_e;

  logic [3:0]            opcode;
  logic [DATA_WIDTH-1:0] imm;

  logic                  sel;
  logic                  ce_acc;
  logic                  ce_r0;
  logic                  rst_code;
  alu_op_e               alu_op;

  logic [DATA_WIDTH-1:0] mux_out;
  logic [DATA_WIDTH-1:0] alu_out;

  logic [DATA_WIDTH-1:0] acc_d, acc_q;
  logic [DATA_WIDTH-1:0] r0_d,  r0_q;

  assign opcode = bus.INSTR[DATA_WIDTH+3:DATA_WIDTH];
  assign imm    = bus.INSTR[DATA_WIDTH-1:0];

  // Instruction decoder; unlisted opcodes fall into the NOP defaults.
  always_comb begin
    sel      = 1'b0;
    ce_acc   = 1'b0;
    ce_r0    = 1'b0;
    rst_code = 1'b0;
    alu_op   = ALU_PASS;
    case (opcode)
      OPC_LDI:  begin sel = 1'b1; alu_op = ALU_PASS; ce_acc = 1'b1; end
      OPC_MOV:  begin ce_r0 = 1'b1; end
      OPC_ADD:  begin sel = 1'b0; alu_op = ALU_ADD;  ce_acc = 1'b1; end
      OPC_SUB:  begin sel = 1'b0; alu_op = ALU_SUB;  ce_acc = 1'b1; end
      OPC_AND:  begin sel = 1'b0; alu_op = ALU_AND;  ce_acc = 1'b1; end
      OPC_ADDI: begin sel = 1'b1; alu_op = ALU_ADD;  ce_acc = 1'b1; end
      OPC_SUBI: begin sel = 1'b1; alu_op = ALU_SUB;  ce_acc = 1'b1; end
      OPC_ANDI: begin sel = 1'b1; alu_op = ALU_AND;  ce_acc = 1'b1; end
      OPC_RST:  begin rst_code = 1'b1; end
      default:  ;
    endcase
  end

  assign mux_out = sel ? imm : acc_q;

  // ALU: operand 1 is always R0; results wrap modulo 2^DATA_WIDTH.
  always_comb begin
    alu_out = mux_out;
    case (alu_op)
      ALU_PASS: alu_out = mux_out;
      ALU_ADD:  alu_out = mux_out + r0_q;
      ALU_SUB:  alu_out = mux_out - r0_q;
      ALU_AND:  alu_out = mux_out & r0_q;
      default:  alu_out = mux_out;
    endcase
  end

  // MOV copies the current (pre-edge) ACC into R0.
  always_comb begin
    acc_d = acc_q;
    r0_d  = r0_q;
    if (ce_acc) acc_d = alu_out;
    if (ce_r0)  r0_d  = acc_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      acc_q <= '0;
      r0_q  <= '0;
    end else begin
      acc_q <= acc_d;
      r0_q  <= r0_d;
    end
  end

  assign bus.RST_CODE = rst_code;
  assign bus.ACC_OUT  = acc_q;
  assign bus.R0_OUT   = r0_q;
  assign bus.ALU_OUT  = alu_out;

endmodule

// File: tb/tb_exec_core.sv
// tb_exec_core: directed bench for exec_core. A behavioural model applies
// each instruction's architectural meaning at every rising edge; a compare
// process checks all outputs against it on each falling edge, and literal
// expectations pin known register values at chosen points in the program.
module tb_exec_core;

  logic       clk;
  logic       rst;
  logic [7:0] instr;

  int unsigned n_checks;
  int unsigned n_fail;

  logic [3:0] acc_m;
  logic [3:0] r0_m;
  logic       model_valid;

  exec_core_if #(.DATA_WIDTH(4)) bus ();
  assign bus.INSTR = instr;

  exec_core #(.DATA_WIDTH(4), .OP_WIDTH(2)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic writes_acc(input logic [3:0] opc);
    return (opc == 4'h1) || ((opc >= 4'h3) && (opc <= 4'h8));
  endfunction

  function automatic logic [3:0] next_acc(input logic [7:0] ins,
                                          input logic [3:0] acc,
                                          input logic [3:0] r0);
    logic [3:0] imm;
    imm = ins[3:0];
    case (ins[7:4])
      4'h1:    return imm;
      4'h3:    return acc + r0;
      4'h4:    return acc - r0;
      4'h5:    return acc & r0;
      4'h6:    return imm + r0;
      4'h7:    return imm - r0;
      4'h8:    return imm & r0;
      default: return acc;
    endcase
  endfunction

  task automatic check(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural state after each rising edge.
  always @(posedge clk) begin
    if (rst) begin
      acc_m       <= 4'h0;
      r0_m        <= 4'h0;
      model_valid <= 1'b1;
    end else if (model_valid) begin
      acc_m <= next_acc(instr, acc_m, r0_m);
      r0_m  <= (instr[7:4] == 4'h2) ? acc_m : r0_m;
    end
  end

  // Per-cycle compare, sampled away from the active edge.
  always @(negedge clk) begin
    if (model_valid === 1'b1) begin
      check("acc_model", {4'h0, bus.ACC_OUT}, {4'h0, acc_m});
      check("r0_model",  {4'h0, bus.R0_OUT},  {4'h0, r0_m});
      if (!$isunknown(instr)) begin
        check("rst_code_model", {7'h0, bus.RST_CODE}, {7'h0, (instr[7:4] == 4'hF)});
        check("alu_model", {4'h0, bus.ALU_OUT},
              {4'h0, writes_acc(instr[7:4]) ? next_acc(instr, acc_m, r0_m) : acc_m});
      end
    end
  end

  task automatic step(input logic r, input logic [7:0] ins);
    rst   = r;
    instr = ins;
    @(posedge clk);
    #2;
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    model_valid = 1'b0;
    acc_m       = 4'h0;
    r0_m        = 4'h0;
    rst         = 1'b1;
    instr       = 8'hxx;

    // Reset, including a cycle with an unknown instruction word.
    step(1'b1, 8'hxx);
    step(1'b1, 8'h15);
    step(1'b1, 8'h15);
    check("reset_acc", {4'h0, bus.ACC_OUT}, 8'h00);
    check("reset_r0",  {4'h0, bus.R0_OUT},  8'h00);
    step(1'b0, 8'h15);
    check("first_ldi", {4'h0, bus.ACC_OUT}, 8'h05);

    // LDI 7, MOV, LDI 3, ADD, SUB
    step(1'b0, 8'h17);
    step(1'b0, 8'h20);
    check("mov_r0", {4'h0, bus.R0_OUT}, 8'h07);
    step(1'b0, 8'h13);
    step(1'b0, 8'h30);
    check("add_acc", {4'h0, bus.ACC_OUT}, 8'h0A);
    step(1'b0, 8'h40);
    check("sub_acc", {4'h0, bus.ACC_OUT}, 8'h03);

    // Wrap-around both directions
    step(1'b0, 8'h1F);
    step(1'b0, 8'h20);
    step(1'b0, 8'h12);
    step(1'b0, 8'h30);
    check("add_wrap", {4'h0, bus.ACC_OUT}, 8'h01);
    step(1'b0, 8'h13);
    step(1'b0, 8'h20);
    step(1'b0, 8'h12);
    step(1'b0, 8'h40);
    check("sub_wrap", {4'h0, bus.ACC_OUT}, 8'h0F);

    // Immediate ops with R0 = 6
    step(1'b0, 8'h16);
    step(1'b0, 8'h20);
    step(1'b0, 8'h65);
    check("addi", {4'h0, bus.ACC_OUT}, 8'h0B);
    step(1'b0, 8'h72);
    check("subi", {4'h0, bus.ACC_OUT}, 8'h0C);
    step(1'b0, 8'h8C);
    check("andi", {4'h0, bus.ACC_OUT}, 8'h04);

    // Restart request: combinational, state holds
    rst   = 1'b0;
    instr = 8'hF0;
    #1;
    check("rst_code_now", {7'h0, bus.RST_CODE}, 8'h01);
    @(posedge clk);
    #2;
    check("rst_hold_acc", {4'h0, bus.ACC_OUT}, 8'h04);
    check("rst_hold_r0",  {4'h0, bus.R0_OUT},  8'h06);

    // NOP and unlisted opcodes
    for (int i = 0; i < 7; i++) begin
      logic [3:0] opc;
      opc   = (i == 0) ? 4'h0 : 4'(8 + i);
      rst   = 1'b0;
      instr = {opc, 4'hA};
      #1;
      check("nop_rst_code", {7'h0, bus.RST_CODE}, 8'h00);
      @(posedge clk);
      #2;
      check("nop_acc", {4'h0, bus.ACC_OUT}, 8'h04);
      check("nop_r0",  {4'h0, bus.R0_OUT},  8'h06);
    end

    // AND with registers: 4 & 6 = 4
    step(1'b0, 8'h50);
    check("and_acc", {4'h0, bus.ACC_OUT}, 8'h04);

    // Reset coinciding with ADD discards the ADD
    step(1'b1, 8'h30);
    check("midrst_acc", {4'h0, bus.ACC_OUT}, 8'h00);
    check("midrst_r0",  {4'h0, bus.R0_OUT},  8'h00);

    // RST_CODE does not depend on RST
    rst   = 1'b1;
    instr = 8'hF3;
    #1;
    check("rst_code_in_reset", {7'h0, bus.RST_CODE}, 8'h01);
    @(posedge clk);
    #2;
    step(1'b0, 8'h19);
    check("post_reset_ldi", {4'h0, bus.ACC_OUT}, 8'h09);
    step(1'b0, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1);
  end

endmodule
